mem_access_unit: RTL

Handshaked memory-access stage that replaces the fixed EX/MEM register for loads and stores. It accepts one memory op from execute, checks alignment, and drives a request/grant/response data bus that can take several cycles and apply backpressure. It formats load data (byte/half/word, signed/unsigned, LWL/LWR merge) and store lanes (SB/SH/SW/SWL/SWR) for either endianness, then presents the result to writeback through a valid/ready handshake. It also reports misalignment, bus-error and timeout exceptions.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/mem_lane_fmt.sv | 64 ++++++
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: op codes, exception codes, FSM states
// and the alignment/classification helpers used by the top and the lane formatter.
package mem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_LWL  = 4'd6,
      OP_LWR  = 4'd7,
      OP_SB   = 4'd8,
      OP_SH   = 4'd9,
      OP_SW   = 4'd10,
      OP_SWL  = 4'd11,
      OP_SWR  = 4'd12
   } mem_op_t;

   typedef enum logic [2:0] {
      EXC_NONE        = 3'd0,
      EXC_MISALIGN_LD = 3'd1,
      EXC_MISALIGN_ST = 3'd2,
      EXC_BUS         = 3'd3,
      EXC_TIMEOUT     = 3'd4
   } exc_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } mau_state_t;

   function automatic logic is_load(mem_op_t op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
   endfunction

   function automatic logic is_store(mem_op_t op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   endfunction

   // Partial-word ops (LWL/LWR/SWL/SWR) and byte ops are legal at any offset.
   function automatic logic misaligned(mem_op_t op, logic [1:0] a);
      logic m;
      m = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: m = a[0];
         OP_LW, OP_SW:         m = (a != 2'b00);
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: store byte-enables/data and load extraction/merge.
// k_i is the big-endian lane index (lane 0 = bits [31:24], sel bit 3).
module mem_lane_fmt
   import mem_pkg::*;
(
   input  mem_op_t             op_i,
   input  logic [1:0]          k_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [SEL_W-1:0]    sel_c_o,
   output logic [DATA_W-1:0]   wdata_c_o,
   output logic [DATA_W-1:0]   ldata_c_o
);

   localparam logic [DATA_W-1:0] ONES = '1;

   logic [4:0]  sh_k;
   logic [4:0]  sh_rk;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign sh_k   = {k_i, 3'b000};
   assign sh_rk  = {~k_i, 3'b000};
   assign lane_b = 8'(rdata_i >> sh_rk);
   assign lane_h = 16'(rdata_i >> {~k_i[1], 4'b0000});

   always_comb begin
      sel_c_o   = '0;
      wdata_c_o = '0;
      ldata_c_o = '0;
      if (is_load(op_i)) sel_c_o = 4'b1111;
      case (op_i)
         OP_LB:  ldata_c_o = {{24{lane_b[7]}}, lane_b};
         OP_LBU: ldata_c_o = {24'h000000, lane_b};
         OP_LH:  ldata_c_o = {{16{lane_h[15]}}, lane_h};
         OP_LHU: ldata_c_o = {16'h0000, lane_h};
         OP_LW:  ldata_c_o = rdata_i;
         OP_LWL: ldata_c_o = (rdata_i << sh_k) | (wdata_i & ~(ONES << sh_k));
         OP_LWR: ldata_c_o = (wdata_i & ~(ONES >> sh_rk)) | (rdata_i >> sh_rk);
         OP_SB: begin
            sel_c_o   = 4'b1000 >> k_i;
            wdata_c_o = {4{wdata_i[7:0]}};
         end
         OP_SH: begin
            sel_c_o   = k_i[1] ? 4'b0011 : 4'b1100;
            wdata_c_o = {2{wdata_i[15:0]}};
         end
         OP_SW: begin
            sel_c_o   = 4'b1111;
            wdata_c_o = wdata_i;
         end
         OP_SWL: begin
            sel_c_o   = 4'b1111 >> k_i;
            wdata_c_o = wdata_i >> sh_k;
         end
         OP_SWR: begin
            sel_c_o   = 4'b1111 << ~k_i;
            wdata_c_o = wdata_i << sh_rk;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked memory-access stage: accepts one op, runs a req/gnt/rvalid bus
// transaction with timeout and flush handling, and presents a formatted result.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TAG_WIDTH      = 16,
   parameter bit          BIG_ENDIAN     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [31:0]           in_wdata,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_sel,
   output logic [31:0]           bus_wdata,
   input  logic                  bus_gnt,
   input  logic                  bus_rvalid,
   input  logic                  bus_err,
   input  logic [31:0]           bus_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_rdata,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [2:0]            out_exc,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   mau_state_t            state_q,     state_d;
   mem_op_t               op_q,        op_d;
   logic [1:0]            k_q,         k_d;
   logic [31:0]           wdata_q,     wdata_d;
   logic                  drop_q,      drop_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic                  bus_req_q,   bus_req_d;
   logic                  bus_we_q,    bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
   logic [3:0]            bus_sel_q,   bus_sel_d;
   logic [31:0]           bus_wdata_q, bus_wdata_d;
   logic                  out_valid_q, out_valid_d;
   logic [31:0]           out_rdata_q, out_rdata_d;
   logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
   exc_t                  out_exc_q,   out_exc_d;

   mem_op_t     in_op_t;
   logic [1:0]  in_k;
   logic        idle;
   mem_op_t     fmt_op;
   logic [1:0]  fmt_k;
   logic [31:0] fmt_wdata;
   logic [3:0]  fmt_sel;
   logic [31:0] fmt_bus_wdata;
   logic [31:0] fmt_ldata;

   assign in_op_t = mem_op_t'(in_op);
   assign in_k    = BIG_ENDIAN ? in_addr[1:0] : ~in_addr[1:0];
   assign idle    = (state_q == S_IDLE);

   // The formatter sees the incoming op while idle (store lanes) and the held op otherwise (load data).
   assign fmt_op    = idle ? in_op_t  : op_q;
   assign fmt_k     = idle ? in_k     : k_q;
   assign fmt_wdata = idle ? in_wdata : wdata_q;

   mem_lane_fmt u_fmt (
      .op_i      (fmt_op),
      .k_i       (fmt_k),
      .wdata_i   (fmt_wdata),
      .rdata_i   (bus_rdata),
      .sel_c_o   (fmt_sel),
      .wdata_c_o (fmt_bus_wdata),
      .ldata_c_o (fmt_ldata)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      k_d         = k_q;
      wdata_d     = wdata_q;
      drop_d      = drop_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      out_valid_d = out_valid_q;
      out_rdata_d = out_rdata_q;
      out_tag_d   = out_tag_q;
      out_exc_d   = out_exc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d      = in_op_t;
               k_d       = in_k;
               wdata_d   = in_wdata;
               out_tag_d = in_tag;
               drop_d    = 1'b0;
               cnt_d     = '0;
               if (misaligned(in_op_t, in_addr[1:0])) begin
                  state_d     = S_RESP;
                  out_valid_d = 1'b1;
                  out_rdata_d = '0;
                  out_exc_d   = is_load(in_op_t) ? EXC_MISALIGN_LD : EXC_MISALIGN_ST;
               end else if (!is_load(in_op_t) && !is_store(in_op_t)) begin
                  state_d     = S_RESP;
                  out_valid_d = 1'b1;
                  out_rdata_d = '0;
                  out_exc_d   = EXC_NONE;
               end else begin
                  state_d     = S_REQ;
                  bus_req_d   = 1'b1;
                  bus_we_d    = is_store(in_op_t);
                  bus_addr_d  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
                  bus_sel_d   = fmt_sel;
                  bus_wdata_d = fmt_bus_wdata;
               end
            end
         end
         S_REQ: begin
            if (bus_gnt) begin
               state_d   = S_WAIT;
               bus_req_d = 1'b0;
               cnt_d     = '0;
               drop_d    = flush;
            end else if (flush) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (flush) drop_d = 1'b1;
            if (bus_rvalid || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
               // A dropped op still waits out its response so the bus stays in step.
               if (drop_q || flush) begin
                  state_d = S_IDLE;
                  drop_d  = 1'b0;
               end else begin
                  state_d     = S_RESP;
                  out_valid_d = 1'b1;
                  out_rdata_d = bus_rvalid ? fmt_ldata : 32'h0;
                  out_exc_d   = bus_rvalid ? (bus_err ? EXC_BUS : EXC_NONE) : EXC_TIMEOUT;
               end
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (flush || out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NONE;
         k_q         <= '0;
         wdata_q     <= '0;
         drop_q      <= 1'b0;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_rdata_q <= '0;
         out_tag_q   <= '0;
         out_exc_q   <= EXC_NONE;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         k_q         <= k_d;
         wdata_q     <= wdata_d;
         drop_q      <= drop_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         out_valid_q <= out_valid_d;
         out_rdata_q <= out_rdata_d;
         out_tag_q   <= out_tag_d;
         out_exc_q   <= out_exc_d;
      end
   end

   assign in_ready  = idle;
   assign busy      = !idle;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_sel   = bus_sel_q;
   assign bus_wdata = bus_wdata_q;
   assign out_valid = out_valid_q;
   assign out_rdata = out_rdata_q;
   assign out_tag   = out_tag_q;
   assign out_exc   = out_exc_q;

endmodule
